// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt dispatcher: FSM state encoding,
// interrupt ID width and a one-hot decode helper.
package irq_pkg;

    localparam int IRQ_ID_W  = 3;
    localparam int ID_SPACE  = 1 << IRQ_ID_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESENT,
        ST_IN_SERVICE,
        ST_CLEAR
    } irq_state_e;

    function automatic logic [ID_SPACE-1:0] id_onehot(input logic [IRQ_ID_W-1:0] id);
        id_onehot     = '0;
        id_onehot[id] = 1'b1;
    endfunction

endpackage

// File: rtl/irq_ack_timer.sv
// Ack-wait counter: cleared by load, advanced by enable, expire flags the
// last cycle of the acknowledge window (count == ACK_TIMEOUT-1).
module irq_ack_timer #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == LAST);

endmodule

// File: rtl/interrupt_dispatcher.sv
// Presents the controller's highest-priority pending interrupt to the CPU,
// tracks ack / end-of-interrupt, and issues a one-hot clear to the controller.
module interrupt_dispatcher
    import irq_pkg::*;
#(
    parameter int NUM_INTERRUPTS = 8,
    parameter int ACK_TIMEOUT    = 255
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      dispatch_enable,
    input  logic                      interrupt_request,
    input  logic [NUM_INTERRUPTS-1:0] interrupt_pending,
    input  logic [IRQ_ID_W-1:0]       highest_priority_int,
    input  logic                      irq_ack,
    input  logic                      irq_eoi,
    input  logic                      clear_timeout,
    output logic                      irq_valid,
    output logic [IRQ_ID_W-1:0]       irq_id,
    output logic [NUM_INTERRUPTS-1:0] clear_interrupt_select,
    output logic                      busy,
    output logic                      timeout_flag,
    output logic                      spurious_pulse,
    output logic [15:0]               dispatch_count
);

    irq_state_e state, state_nx;

    logic                      valid_nx;
    logic [IRQ_ID_W-1:0]       id_nx;
    logic [NUM_INTERRUPTS-1:0] clr_nx;
    logic                      spur_nx;
    logic                      busy_nx;
    logic                      count_inc;
    logic                      timeout_set;
    logic                      timer_load;
    logic                      timer_en;
    logic                      timer_expire;
    logic [ID_SPACE-1:0]       pend_ext;
    logic [ID_SPACE-1:0]       id_hot;

    // Zero-extended so IDs beyond NUM_INTERRUPTS read as not pending.
    assign pend_ext = ID_SPACE'(interrupt_pending);
    assign id_hot   = id_onehot(irq_id);

    irq_ack_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_ack_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (timer_load),
        .enable  (timer_en),
        .expire  (timer_expire)
    );

    always_comb begin
        state_nx    = state;
        valid_nx    = irq_valid;
        id_nx       = irq_id;
        clr_nx      = '0;
        spur_nx     = 1'b0;
        count_inc   = 1'b0;
        timeout_set = 1'b0;
        timer_load  = 1'b0;
        timer_en    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (dispatch_enable && interrupt_request && pend_ext[highest_priority_int]) begin
                    state_nx   = ST_PRESENT;
                    valid_nx   = 1'b1;
                    id_nx      = highest_priority_int;
                    timer_load = 1'b1;
                end
            end
            ST_PRESENT: begin
                // Ack beats withdrawal, withdrawal beats timeout.
                if (irq_ack) begin
                    state_nx  = ST_IN_SERVICE;
                    valid_nx  = 1'b0;
                    count_inc = 1'b1;
                end else if (!pend_ext[irq_id]) begin
                    state_nx = ST_IDLE;
                    valid_nx = 1'b0;
                    spur_nx  = 1'b1;
                end else if (timer_expire) begin
                    state_nx    = ST_CLEAR;
                    valid_nx    = 1'b0;
                    timeout_set = 1'b1;
                    clr_nx      = id_hot[NUM_INTERRUPTS-1:0];
                end else begin
                    timer_en = 1'b1;
                end
            end
            ST_IN_SERVICE: begin
                if (irq_eoi) begin
                    state_nx = ST_CLEAR;
                    clr_nx   = id_hot[NUM_INTERRUPTS-1:0];
                end
            end
            ST_CLEAR: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        busy_nx = (state_nx != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state                  <= ST_IDLE;
            irq_valid              <= 1'b0;
            irq_id                 <= '0;
            clear_interrupt_select <= '0;
            busy                   <= 1'b0;
            timeout_flag           <= 1'b0;
            spurious_pulse         <= 1'b0;
            dispatch_count         <= '0;
        end else begin
            state                  <= state_nx;
            irq_valid              <= valid_nx;
            irq_id                 <= id_nx;
            clear_interrupt_select <= clr_nx;
            busy                   <= busy_nx;
            spurious_pulse         <= spur_nx;
            if (timeout_set) begin
                timeout_flag <= 1'b1;
            end else if (clear_timeout) begin
                timeout_flag <= 1'b0;
            end
            if (count_inc && (dispatch_count != 16'hFFFF)) begin
                dispatch_count <= dispatch_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_interrupt_dispatcher.sv
// Transaction-level bench: an emulated fixed-priority controller feeds the
// dispatcher while each dispatch's outcome is predicted from the event timing.
module tb_interrupt_dispatcher;

    localparam int NUM = 8;
    localparam int TMO = 4;
    localparam int K_ACK = 0;
    localparam int K_SP  = 1;
    localparam int K_TO  = 2;

    logic           clock = 1'b0;
    logic           reset_n;
    logic           dispatch_enable;
    logic           interrupt_request;
    logic [NUM-1:0] interrupt_pending;
    logic [2:0]     highest_priority_int;
    logic           irq_ack;
    logic           irq_eoi;
    logic           clear_timeout;
    logic           irq_valid;
    logic [2:0]     irq_id;
    logic [NUM-1:0] clear_interrupt_select;
    logic           busy;
    logic           timeout_flag;
    logic           spurious_pulse;
    logic [15:0]    dispatch_count;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] pend;
    int         model_cnt;
    bit         model_flag;

    interrupt_dispatcher #(
        .NUM_INTERRUPTS (NUM),
        .ACK_TIMEOUT    (TMO)
    ) dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .dispatch_enable        (dispatch_enable),
        .interrupt_request      (interrupt_request),
        .interrupt_pending      (interrupt_pending),
        .highest_priority_int   (highest_priority_int),
        .irq_ack                (irq_ack),
        .irq_eoi                (irq_eoi),
        .clear_timeout          (clear_timeout),
        .irq_valid              (irq_valid),
        .irq_id                 (irq_id),
        .clear_interrupt_select (clear_interrupt_select),
        .busy                   (busy),
        .timeout_flag           (timeout_flag),
        .spurious_pulse         (spurious_pulse),
        .dispatch_count         (dispatch_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fixed priority: lowest set index wins.
    function automatic logic [2:0] prio(input logic [7:0] p);
        prio = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (p[i]) prio = 3'(i);
        end
    endfunction

    task automatic drive_ctrl();
        interrupt_pending    = pend;
        interrupt_request    = |pend;
        highest_priority_int = prio(pend);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, irq_valid, 0);
        chk({tag, "_id"}, irq_id, 0);
        chk({tag, "_clr"}, clear_interrupt_select, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_flag"}, timeout_flag, 0);
        chk({tag, "_spur"}, spurious_pulse, 0);
        chk({tag, "_count"}, dispatch_count, 0);
    endtask

    // One complete dispatch. ack_wait: valid cycle index at which ack is raised
    // (>= TMO means never); drop_at: index at which the pending bit is withdrawn (-1 never).
    task automatic serve(input logic [7:0] add, input int ack_wait, input int drop_at,
                         input int eoi_wait, input bit clr_hold, input bit en_drop,
                         input bit eoi_noise, input bit rst_mid);
        logic [2:0] id;
        logic [7:0] hot;
        int         e;
        int         kind;
        int         vlen;

        pend = pend | add;
        drive_ctrl();
        dispatch_enable = 1'b1;
        id  = prio(pend);
        hot = 8'd1 << id;

        e = TMO - 1;
        kind = K_TO;
        if (drop_at >= 0 && drop_at <= e) begin
            e = drop_at;
            kind = K_SP;
        end
        if (ack_wait <= e) begin
            e = ack_wait;
            kind = K_ACK;
        end

        tick();
        chk("disp_valid", irq_valid, 1);
        chk("disp_id", irq_id, id);
        chk("disp_busy", busy, 1);
        chk("disp_spur", spurious_pulse, 0);
        chk("disp_clr", clear_interrupt_select, 0);

        vlen = 0;
        for (int k = 0; k < TMO + 2; k++) begin
            if (irq_valid !== 1'b1) break;
            vlen++;
            chk("present_id", irq_id, id);
            irq_ack = (k == ack_wait);
            if (k == drop_at) begin
                pend[id] = 1'b0;
                drive_ctrl();
            end
            clear_timeout = clr_hold;
            irq_eoi = eoi_noise;
            if (en_drop) dispatch_enable = 1'b0;
            tick();
        end
        irq_ack = 1'b0;
        clear_timeout = 1'b0;
        irq_eoi = 1'b0;
        chk("valid_len", vlen, e + 1);

        if (kind == K_ACK) begin
            if (clr_hold) model_flag = 1'b0;
            if (model_cnt < 16'hFFFF) model_cnt++;
            chk("ack_count", dispatch_count, model_cnt);
            chk("ack_busy", busy, 1);
            chk("ack_id", irq_id, id);
            chk("ack_spur", spurious_pulse, 0);
            chk("ack_clr", clear_interrupt_select, 0);
            chk("ack_flag", timeout_flag, model_flag);
            if (rst_mid) begin
                reset_n = 1'b0;
                tick();
                chk_all_zero("rst_mid");
                reset_n = 1'b1;
                model_cnt = 0;
                model_flag = 1'b0;
                pend = 8'h00;
                drive_ctrl();
                tick();
                chk("rst_noclr", clear_interrupt_select, 0);
                chk("rst_idle", busy, 0);
                return;
            end
            for (int i = 0; i < eoi_wait; i++) begin
                irq_ack = i[0];
                tick();
                chk("svc_valid", irq_valid, 0);
                chk("svc_busy", busy, 1);
            end
            irq_ack = 1'b0;
            irq_eoi = 1'b1;
            tick();
            irq_eoi = 1'b0;
            chk("eoi_clr", clear_interrupt_select, hot);
            chk("eoi_valid", irq_valid, 0);
            pend[id] = 1'b0;
            drive_ctrl();
            tick();
            chk("end_clr", clear_interrupt_select, 0);
            chk("end_busy", busy, 0);
            chk("end_valid", irq_valid, 0);
        end else if (kind == K_TO) begin
            model_flag = 1'b1;
            chk("to_clr", clear_interrupt_select, hot);
            chk("to_flag", timeout_flag, 1);
            chk("to_busy", busy, 1);
            chk("to_spur", spurious_pulse, 0);
            pend[id] = 1'b0;
            drive_ctrl();
            tick();
            chk("to_end_clr", clear_interrupt_select, 0);
            chk("to_end_busy", busy, 0);
            chk("to_count", dispatch_count, model_cnt);
        end else begin
            if (clr_hold) model_flag = 1'b0;
            chk("sp_pulse", spurious_pulse, 1);
            chk("sp_clr", clear_interrupt_select, 0);
            chk("sp_busy", busy, 0);
            chk("sp_valid", irq_valid, 0);
            chk("sp_flag", timeout_flag, model_flag);
            chk("sp_count", dispatch_count, model_cnt);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        dispatch_enable = 1'b0;
        irq_ack = 1'b0;
        irq_eoi = 1'b0;
        clear_timeout = 1'b0;
        pend = 8'h00;
        model_cnt = 0;
        model_flag = 1'b0;
        drive_ctrl();
        tick();
        tick();
        chk_all_zero("reset");
        reset_n = 1'b1;
        tick();

        serve(8'h10, 3, -1, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        dispatch_enable = 1'b0;
        chk("basic_count", dispatch_count, 1);

        serve(8'h01, 99, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        dispatch_enable = 1'b0;
        clear_timeout = 1'b1;
        tick();
        clear_timeout = 1'b0;
        model_flag = 1'b0;
        chk("to_cleared", timeout_flag, 0);

        serve(8'h04, 99, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        dispatch_enable = 1'b0;
        tick();
        chk("sp_one_cycle", spurious_pulse, 0);

        serve(8'h04, 1, 1, 2, 1'b0, 1'b0, 1'b1, 1'b0);
        dispatch_enable = 1'b0;

        serve(8'h08, 0, -1, 0, 1'b0, 1'b0, 1'b0, 1'b1);

        serve(8'h06, 0, -1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        serve(8'h00, 2, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        dispatch_enable = 1'b0;

        pend = 8'h20;
        drive_ctrl();
        irq_eoi = 1'b1;
        tick();
        tick();
        irq_eoi = 1'b0;
        chk("blocked_en_valid", irq_valid, 0);
        chk("blocked_en_busy", busy, 0);
        dispatch_enable = 1'b1;
        interrupt_request = 1'b0;
        tick();
        chk("blocked_req_valid", irq_valid, 0);
        dispatch_enable = 1'b0;
        drive_ctrl();

        serve(8'h00, 99, -1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        dispatch_enable = 1'b0;

        for (int n = 0; n < 60; n++) begin
            logic [7:0] add;
            int         aw;
            int         dr;
            add = 8'($urandom) & 8'($urandom);
            add = add | (8'd1 << $urandom_range(0, 7));
            aw  = int'($urandom_range(0, 5));
            dr  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : -1;
            serve(add, aw, dr, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 19) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/interrupt_dispatcher.md
INTERRUPT_DISPATCHER -- requirements
Module: interrupt_dispatcher

Interface
REQ-001 SHALL have parameter NUM_INTERRUPTS, default 8, the number of interrupt lines (max 8, 3-bit IDs).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 255, the number of cycles irq_valid waits for irq_ack (range 1..65535).
REQ-003 SHALL have port clock  in  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port dispatch_enable  in  1  permits new dispatches from IDLE.
REQ-006 SHALL have port interrupt_request  in  1  combined request from the interrupt controller.
REQ-007 SHALL have port interrupt_pending  in  NUM_INTERRUPTS  pending status from the controller.
REQ-008 SHALL have port highest_priority_int  in  3  highest-priority pending ID from the controller.
REQ-009 SHALL have port irq_ack  in  1  CPU accepts the presented interrupt.
REQ-010 SHALL have port irq_eoi  in  1  CPU end-of-interrupt.
REQ-011 SHALL have port clear_timeout  in  1  clears timeout_flag.
REQ-012 SHALL have port irq_valid  out  1  an interrupt is presented to the CPU.
REQ-013 SHALL have port irq_id  out  3  the ID being presented or in service.
REQ-014 SHALL have port clear_interrupt_select  out  NUM_INTERRUPTS  one-hot clear pulse to the controller.
REQ-015 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-016 SHALL have port timeout_flag  out  1  sticky flag: an ack timeout occurred.
REQ-017 SHALL have port spurious_pulse  out  1  one-cycle pulse when a presented interrupt is withdrawn.
REQ-018 SHALL have port dispatch_count  out  16  number of acknowledged dispatches, saturating.

Function
REQ-019 SHALL implement the FSM states IDLE, PRESENT, IN_SERVICE and CLEAR; all outputs are registered.
REQ-020 IDLE: if dispatch_enable, interrupt_request and interrupt_pending[highest_priority_int] are all 1 at an edge, SHALL latch highest_priority_int into irq_id and enter PRESENT; irq_valid goes to 1 in the next cycle.
REQ-021 PRESENT: SHALL hold irq_valid=1 and irq_id stable; the ack-wait counter starts at 0 on entry and increments each cycle.
REQ-022 PRESENT with irq_ack=1 SHALL enter IN_SERVICE and increment dispatch_count (saturating at 16'hFFFF); irq_valid drops in the next cycle.
REQ-023 PRESENT with irq_ack=0 and interrupt_pending[irq_id]=0 SHALL pulse spurious_pulse for one cycle and return to IDLE without a clear pulse.
REQ-024 PRESENT with irq_ack=0 and counter==ACK_TIMEOUT-1 SHALL set timeout_flag and enter CLEAR, so irq_valid is high for exactly ACK_TIMEOUT cycles.
REQ-025 Simultaneous events in PRESENT SHALL resolve with priority ack > withdrawal > timeout.
REQ-026 IN_SERVICE SHALL hold irq_id, keep irq_valid=0, ignore irq_ack, and enter CLEAR on irq_eoi=1.
REQ-027 irq_eoi outside IN_SERVICE SHALL be ignored.
REQ-028 CLEAR SHALL drive clear_interrupt_select = one-hot(irq_id) for exactly one cycle, then enter IDLE; the output is 0 in all other states.
REQ-029 IDLE entered from CLEAR SHALL evaluate the request in that same cycle, giving back-to-back dispatch with a minimum one-cycle IDLE gap.
REQ-030 dispatch_enable=0 SHALL only block IDLE->PRESENT and SHALL NOT abort a dispatch in progress.
REQ-031 timeout_flag SHALL clear on clear_timeout=1; if clear_timeout and a new timeout occur in the same cycle, set wins.
REQ-032 highest_priority_int values >= NUM_INTERRUPTS SHALL be treated as no request.

Reset
REQ-033 With reset_n=0 at an edge, the state SHALL go to IDLE and irq_valid, irq_id, clear_interrupt_select, busy, timeout_flag, spurious_pulse, dispatch_count and the counter SHALL all be 0, including when reset arrives mid-dispatch; no clear pulse is issued on reset.

Structure
REQ-034 The FSM state enum and the ID width constant (3) SHALL reside in a shared package, irq_pkg.
REQ-035 The ack-wait counter SHALL be a sub-module, irq_ack_timer (load/enable/expire), sized to hold ACK_TIMEOUT.

Verification
REQ-036 Pending=8'h10, ID=4, ack 3 cycles after irq_valid, eoi 5 cycles later -> irq_id=4, clear_interrupt_select=8'h10 for one cycle, dispatch_count=1.
REQ-037 ACK_TIMEOUT=4, no ack -> irq_valid high for exactly 4 cycles, then timeout_flag=1, clear pulse 8'h01 (ID 0); clear_timeout -> flag returns to 0.
REQ-038 Pending bit 2 drops while in PRESENT -> spurious_pulse one cycle, no clear pulse, return to IDLE.
REQ-039 Ack and pending drop in the same cycle -> IN_SERVICE, no spurious_pulse.
REQ-040 reset_n=0 during IN_SERVICE -> all outputs 0 on the next cycle, FSM in IDLE.
REQ-041 Pending=8'h06 with fixed priority -> ID 1 dispatched and cleared, then ID 2 dispatched after a one-cycle IDLE gap.
